// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling and a one-entry
// output register with valid/ready handshake, overrun and frame-error pulses.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int RX_BAUD  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BAUD_DIV = CLK_FREQ / RX_BAUD;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             rx_m_q, rx_s_q;
  logic [1:0]       fill_q;
  logic             armed_q;
  logic [7:0]       data_q;
  logic             valid_q, frame_err_q, overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end

  // fill_q marks when rx_s_q carries a real line sample rather than the reset
  // value, so a line held low across reset can never arm start detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (valid_q && ready) valid_q <= 1'b0;
      if (!fill_q[1]) fill_q <= fill_q + 2'd1;
      if (fill_q[1] && rx_s_q) armed_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (armed_q && !rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            bit_q <= '0;
            state_q <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
              // A consume in this same cycle frees the slot for the new byte.
              if (!valid_q || ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= RECOVER;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RECOVER: begin
          if (rx_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default 50 MHz / 115200 baud (434 clk/bit):
// a table of single frames plus hand-written glitch, recovery, overrun and reset sequences.
module tb_uart_rx;

  localparam int BIT = 434;
  localparam int COMPLETE = 4125;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  uart_rx dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int   v_rise = 0, v_hi = 0, fe_n = 0, ov_n = 0;
  int   fe_run = 0, ov_run = 0, fe_max = 0, ov_max = 0;
  logic v_prev = 1'b0;

  always @(negedge clk) begin
    if (valid) v_hi++;
    if (valid && !v_prev) v_rise++;
    v_prev = valid;
    if (frame_err) begin
      fe_n++; fe_run++;
      if (fe_run > fe_max) fe_max = fe_run;
    end else fe_run = 0;
    if (overrun) begin
      ov_n++; ov_run++;
      if (ov_run > ov_max) ov_max = ov_run;
    end else ov_run = 0;
  end

  int s_rise, s_hi, s_fe, s_ov;

  task automatic snap();
    s_rise = v_rise; s_hi = v_hi; s_fe = fe_n; s_ov = ov_n;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] byt;
    logic       stop;
    int         exp_vld;
    int         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{byt: 8'hA3, stop: 1'b1, exp_vld: 1, exp_fe: 0, exp_data: 8'hA3};
    vecs[1] = '{byt: 8'h55, stop: 1'b1, exp_vld: 1, exp_fe: 0, exp_data: 8'h55};
    vecs[2] = '{byt: 8'h3C, stop: 1'b0, exp_vld: 0, exp_fe: 1, exp_data: 8'h55};
    vecs[3] = '{byt: 8'hC6, stop: 1'b1, exp_vld: 1, exp_fe: 0, exp_data: 8'hC6};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_data", int'(data), 8'h00);
    chk("reset_valid", int'(valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst = 1'b1;
    idle(20);

    // Start-bit glitch
    snap();
    rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(2 * BIT);
    chk("glitch_valid", v_rise - s_rise, 0);
    chk("glitch_frame_err", fe_n - s_fe, 0);

    // Table of single frames with ready held high
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      snap();
      send_frame(vecs[i].byt, vecs[i].stop);
      idle(2 * BIT);
      chk($sformatf("vec%0d_valid_rise", i), v_rise - s_rise, vecs[i].exp_vld);
      chk($sformatf("vec%0d_valid_cycles", i), v_hi - s_hi, vecs[i].exp_vld);
      chk($sformatf("vec%0d_frame_err", i), fe_n - s_fe, vecs[i].exp_fe);
      chk($sformatf("vec%0d_overrun", i), ov_n - s_ov, 0);
      chk($sformatf("vec%0d_data", i), int'(data), int'(vecs[i].exp_data));
    end

    // Bad stop bit then line held low: must stay in RECOVER
    snap();
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    chk("recover_frame_err", fe_n - s_fe, 1);
    chk("recover_valid", v_rise - s_rise, 0);
    idle(2 * BIT);
    send_frame(8'h5A, 1'b1);
    idle(2 * BIT);
    chk("after_recover_valid", v_rise - s_rise, 1);
    chk("after_recover_data", int'(data), 8'h5A);

    // Back-to-back with ready low: second byte overruns
    ready = 1'b0;
    snap();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    chk("b2b_valid", int'(valid), 1);
    chk("b2b_data", int'(data), 8'h00);
    chk("b2b_overrun", ov_n - s_ov, 1);
    chk("b2b_frame_err", fe_n - s_fe, 0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("b2b_consumed", int'(valid), 0);

    // ready asserted exactly on the completion cycle of the second byte
    snap();
    send_frame(8'h00, 1'b1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (COMPLETE) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("same_cycle_valid", int'(valid), 1);
        chk("same_cycle_data", int'(data), 8'hFF);
      end
    join
    idle(20);
    chk("same_cycle_overrun", ov_n - s_ov, 0);
    chk("same_cycle_valid_held", int'(valid), 1);
    chk("same_cycle_data_held", int'(data), 8'hFF);

    // Reset during data bit 4 of 0x0F
    snap();
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT) @(negedge clk);
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midreset_data", int'(data), 8'h00);
    chk("midreset_valid", int'(valid), 0);
    rst = 1'b1;
    repeat (BIT - 205 + 3 * BIT) @(negedge clk);
    rx = 1'b1;
    idle(3 * BIT);
    chk("midreset_no_frame_err", fe_n - s_fe, 0);
    chk("midreset_no_overrun", ov_n - s_ov, 0);
    chk("midreset_no_valid", int'(valid), 0);
    ready = 1'b1;
    snap();
    send_frame(8'h81, 1'b1);
    idle(2 * BIT);
    chk("post_reset_valid", v_rise - s_rise, 1);
    chk("post_reset_data", int'(data), 8'h81);

    chk("frame_err_max_run", fe_max, 1);
    chk("overrun_max_run", ov_max, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter RX_BAUD, default 115200, serial bit rate.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port data  output  8  received byte.
REQ-007 SHALL have port valid  output  1  data holds an unconsumed byte.
REQ-008 SHALL have port ready  input  1  consumer accepts data when valid && ready.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-011 SHALL compute BAUD_DIV = CLK_FREQ / RX_BAUD, truncated (434 at defaults), and HALF = BAUD_DIV / 2 (217).
REQ-012 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, RECOVER with a baud counter wide enough for BAUD_DIV-1 and a 3-bit bit index.
REQ-014 IDLE: on rx_s 1->0 while armed -> START with baud counter cleared.
REQ-015 START: at count HALF-1 sample rx_s; 0 -> DATA with counter cleared, 1 -> IDLE (glitch rejected, no output activity).
REQ-016 DATA: every BAUD_DIV cycles sample rx_s into the shift register, LSB first; after bit 7 -> STOP.
REQ-017 STOP: after BAUD_DIV cycles sample rx_s; 1 -> byte complete, IDLE; 0 -> frame_err pulse, byte discarded, RECOVER.
REQ-018 RECOVER: remain until rx_s = 1, then IDLE; no start detection while in RECOVER.
REQ-019 On byte complete, data and valid SHALL update on the clock edge following the stop-bit sample (1-cycle latency).
REQ-020 valid SHALL stay high and data stable until a cycle with valid && ready; valid then clears on the next edge.
REQ-021 Byte completes while valid=1 and ready=0: overrun pulses one cycle, old data kept, new byte dropped.
REQ-022 Byte completes in the same cycle as valid && ready: new byte loaded, valid stays 1, no overrun.
REQ-023 Frame timing SHALL be re-aligned at each start edge; no accumulated drift across bytes.
REQ-024 Back-to-back frames with zero idle between stop and next start SHALL be received without loss.
REQ-025 frame_err and overrun SHALL never be asserted for more than one consecutive cycle per event.

Reset
REQ-026 While rst=0: state IDLE, counters 0, data=8'h00, valid=0, frame_err=0, overrun=0, synchronizer flops=1, armed=0.
REQ-027 After rst deasserts, armed SHALL set only after rx_s is observed 1, so reset mid-frame never decodes a partial frame.
REQ-028 Reset asserted mid-frame SHALL abort reception immediately with no valid, frame_err or overrun generated.

Verification
REQ-029 Frame 0x55 at 434 clk/bit, ready=1 -> valid pulses one cycle with data=8'h55, frame_err=0.
REQ-030 rx low for 100 cycles then high -> no valid, no frame_err; subsequent frame 0xA3 received correctly.
REQ-031 Frame 0x3C with stop bit driven 0 -> frame_err one-cycle pulse, valid stays 0; rx held low stays in RECOVER until rx=1.
REQ-032 Back-to-back 0x00 then 0xFF, ready=0 -> valid=1, data=8'h00, overrun one pulse; ready=1 then consumes 0x00, valid drops.
REQ-033 ready asserted on the exact cycle the second byte completes -> data=8'hFF, valid stays 1, overrun=0.
REQ-034 rst pulsed low during data bit 4 of a frame -> outputs at reset values, remainder of frame ignored, next full frame 0x81 received.
